// File: rtl/mem_stall_controller.sv
// Pipeline stall controller for a blocking cache: freezes the core while a read
// miss is fetched and filled, or while a write-through store reaches memory.
module mem_stall_controller #(
    parameter int MEM_LATENCY = 4,
    parameter int MISS_W      = 16
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              access_valid,
    input  logic              mem_write,
    input  logic              hit,
    input  logic [31:0]       addr,
    input  logic              halted,
    output logic              freeze,
    output logic              mem_read_req,
    output logic              mem_write_en,
    output logic [31:0]       mem_addr,
    output logic              fill_en,
    output logic [MISS_W-1:0] miss_count,
    output logic [31:0]       stall_cycles,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        READ_WAIT  = 3'd1,
        FILL       = 3'd2,
        WRITE_WAIT = 3'd3,
        DONE       = 3'd4
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [31:0]         addr_q;
    logic [MISS_W-1:0]   miss_q;
    logic [MISS_W-1:0]   miss_d;
    logic [31:0]         stall_q;
    logic                rd_q;
    logic                wen_q;
    logic                fill_q;
    logic                accept_rd;
    logic                accept_wr;
    logic                busy;

    // Acceptance is gated by rst_b so freeze reads 0 for the whole reset window.
    assign accept_rd = rst_b && (state_q == IDLE) && access_valid && !halted && !mem_write && !hit;
    assign accept_wr = rst_b && (state_q == IDLE) && access_valid && !halted && mem_write;
    assign busy      = (state_q == READ_WAIT) || (state_q == FILL) || (state_q == WRITE_WAIT);
    assign miss_d    = (miss_q == '1) ? miss_q : miss_q + 1'b1;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            miss_q  <= '0;
            stall_q <= 32'd0;
            rd_q    <= 1'b0;
            wen_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            rd_q    <= 1'b0;
            wen_q   <= 1'b0;
            fill_q  <= 1'b0;
            stall_q <= stall_q + 32'(freeze);
            case (state_q)
                IDLE: begin
                    if (accept_rd) begin
                        state_q <= READ_WAIT;
                        cnt_q   <= LAT_M1;
                        addr_q  <= addr;
                        miss_q  <= miss_d;
                        rd_q    <= 1'b1;
                    end else if (accept_wr) begin
                        state_q <= WRITE_WAIT;
                        cnt_q   <= LAT_M1;
                        addr_q  <= addr;
                        wen_q   <= 1'b1;
                    end
                end
                READ_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= FILL;
                        fill_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        rd_q  <= 1'b1;
                    end
                end
                FILL: state_q <= DONE;
                // Write strobe only fires on entry, so later WRITE_WAIT cycles are quiet.
                WRITE_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign freeze       = busy || accept_rd || accept_wr;
    assign mem_read_req = rd_q;
    assign mem_write_en = wen_q;
    assign fill_en      = fill_q;
    assign mem_addr     = addr_q;
    assign miss_count   = miss_q;
    assign stall_cycles = stall_q;
    assign dbg_state    = state_q;

endmodule
